// File: rtl/sram_line_ctrl.sv
// Line-fill / write-through controller for a 256K x 16 async SRAM; a read takes 4(1+WAIT_CYCLES)+1 cycles, a write 2(1+WAIT_CYCLES)+1.
// Requests are latched in IDLE; pause stays high while busy so the requester holds and stalls.
module sram_line_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wr_data,
    output logic [63:0] rd_data,
    output logic        ready,
    output logic        pause,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_dq,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [2:0] WMAX = 3'(WAIT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] la;
    logic        ws;
    logic [31:0] wdat;
    logic [1:0]  k;
    logic [2:0]  w;
    logic        op_rd;
    logic        last;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        unused_addr;

    assign last        = (w == WMAX);
    assign unused_addr = ^{address[31:19], address[1:0]};
    assign sram_ub_n   = 1'b0;
    assign sram_lb_n   = 1'b0;
    assign sram_dq     = dq_oe ? dq_out : 16'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rd_data <= '0;
            la      <= '0;
            ws      <= 1'b0;
            wdat    <= '0;
            k       <= '0;
            w       <= '0;
            op_rd   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // Write wins a tie; a still-held read is taken on the next IDLE.
                    if (wr_en) begin
                        la    <= address[18:3];
                        ws    <= address[2];
                        wdat  <= wr_data;
                        k     <= '0;
                        w     <= '0;
                        op_rd <= 1'b0;
                    end else if (rd_en) begin
                        la    <= address[18:3];
                        ws    <= address[2];
                        k     <= '0;
                        w     <= '0;
                        op_rd <= 1'b1;
                    end
                end
                READ: begin
                    if (last) begin
                        rd_data[{k, 4'b0000} +: 16] <= sram_dq;
                        w <= '0;
                        k <= k + 2'd1;
                    end else begin
                        w <= w + 3'd1;
                    end
                end
                WRITE: begin
                    if (last) begin
                        w <= '0;
                        k <= k + 2'd1;
                    end else begin
                        w <= w + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        pause     = 1'b0;
        ready     = 1'b0;
        sram_addr = '0;
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = wdat[15:0];
        case (state)
            IDLE: begin
                pause = rd_en | wr_en;
                if (wr_en)      state_nxt = WRITE;
                else if (rd_en) state_nxt = READ;
            end
            READ: begin
                pause     = 1'b1;
                sram_addr = {la, k};
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                if (last && (k == 2'd3)) state_nxt = DONE;
            end
            WRITE: begin
                pause     = 1'b1;
                sram_addr = {la, ws, k[0]};
                sram_ce_n = 1'b0;
                // we_n rises for the final cycle so address/data are stable at its rising edge.
                sram_we_n = last;
                dq_oe     = 1'b1;
                dq_out    = k[0] ? wdat[31:16] : wdat[15:0];
                if (last && k[0]) state_nxt = DONE;
            end
            DONE: begin
                ready     = op_rd;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            pause = 1'b0;
            ready = 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_line_ctrl.sv
// Directed bench for sram_line_ctrl with a behavioural async SRAM on the data bus.
module tb_sram_line_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] wr_data;
    logic [63:0] rd_data;
    logic        ready;
    logic        pause;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    always #5 clk = ~clk;

    sram_line_ctrl #(.WAIT_CYCLES(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .address   (address),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .ready     (ready),
        .pause     (pause),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n)
    );

    logic [15:0] mem [0:262143];
    logic        pl_go = 1'b0;
    logic [17:0] pl_addr;
    logic [15:0] pl_data;

    always @(posedge sram_we_n or posedge pl_go) begin
        if (pl_go)
            mem[pl_addr] <= pl_data;
        else if (sram_ce_n == 1'b0)
            mem[sram_addr] <= sram_dq;
    end

    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'bz;

    int passed = 0;
    int total  = 0;
    int pause_cnt, ready_cnt, ready_cyc, wel_cnt, done_cyc, n_addr;
    logic [17:0] addr_log [8];

    typedef struct {
        logic [31:0] addr;
        logic [63:0] line;
        logic [17:0] a0;
    } rd_vec_t;
    rd_vec_t vt [3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        #1 pl_go = 1'b1;
        #1 pl_go = 1'b0;
        #1;
    endtask

    // Cycle 0 is the IDLE cycle that sees the request; ends at the first later cycle with pause low.
    task automatic run_op(input logic r, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic hold_rd);
        pause_cnt = 0; ready_cnt = 0; ready_cyc = -1; wel_cnt = 0; done_cyc = -1; n_addr = 0;
        @(negedge clk);
        rd_en = r; wr_en = wr; address = a; wr_data = d;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (pause) pause_cnt++;
            if (ready) begin ready_cnt++; ready_cyc = c; end
            if (!sram_we_n) wel_cnt++;
            if (!sram_ce_n && n_addr < 8 && (n_addr == 0 || addr_log[n_addr-1] != sram_addr)) begin
                addr_log[n_addr] = sram_addr;
                n_addr++;
            end
            if (c > 0 && !pause) begin
                done_cyc = c;
                break;
            end
        end
        wr_en = 1'b0;
        if (!hold_rd) rd_en = 1'b0;
    endtask

    initial begin
        vt[0] = '{addr: 32'h0000_0020, line: 64'h4444_3333_2222_1111, a0: 18'h00010};
        vt[1] = '{addr: 32'hFFFF_FFF8, line: 64'hD3D3_C2C2_B1B1_A0A0, a0: 18'h3FFFC};
        vt[2] = '{addr: 32'h8000_0027, line: 64'h4444_3333_2222_1111, a0: 18'h00010};

        rst = 1'b1; rd_en = 1'b1; wr_en = 1'b0; address = 32'h20; wr_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pause", {63'd0, pause}, 64'd0);
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_ctl_n", {61'd0, sram_ce_n, sram_oe_n, sram_we_n}, 64'd7);
        chk("rst_sram_addr", {46'd0, sram_addr}, 64'd0);
        chk("byte_lanes", {62'd0, sram_ub_n, sram_lb_n}, 64'd0);
        rst = 1'b0; rd_en = 1'b0;

        preload(18'h00010, 16'h1111);
        preload(18'h00011, 16'h2222);
        preload(18'h00012, 16'h3333);
        preload(18'h00013, 16'h4444);
        preload(18'h3FFFC, 16'hA0A0);
        preload(18'h3FFFD, 16'hB1B1);
        preload(18'h3FFFE, 16'hC2C2);
        preload(18'h3FFFF, 16'hD3D3);

        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, 1'b0, vt[i].addr, 32'd0, 1'b0);
            chk("rd_pause_cycles", 64'(pause_cnt), 64'd9);
            chk("rd_done_cycle", 64'(done_cyc), 64'd9);
            chk("rd_ready_cycle", 64'(ready_cyc), 64'd9);
            chk("rd_ready_count", 64'(ready_cnt), 64'd1);
            chk("rd_line", rd_data, vt[i].line);
            chk("rd_access_count", 64'(n_addr), 64'd4);
            for (int j = 0; j < 4; j++)
                chk("rd_addr_seq", {46'd0, addr_log[j]}, {46'd0, 18'(vt[i].a0 + 18'(j))});
        end

        repeat (3) @(negedge clk);
        #1;
        chk("rd_data_hold", rd_data, 64'h4444_3333_2222_1111);

        run_op(1'b0, 1'b1, 32'h24, 32'hDEAD_BEEF, 1'b0);
        chk("wr_pause_cycles", 64'(pause_cnt), 64'd5);
        chk("wr_done_cycle", 64'(done_cyc), 64'd5);
        chk("wr_ready_count", 64'(ready_cnt), 64'd0);
        chk("wr_we_low_cycles", 64'(wel_cnt), 64'd2);
        chk("wr_addr0", {46'd0, addr_log[0]}, 64'h12);
        chk("wr_addr1", {46'd0, addr_log[1]}, 64'h13);
        chk("wr_mem_lo", {48'd0, mem[18'h12]}, 64'hBEEF);
        chk("wr_mem_hi", {48'd0, mem[18'h13]}, 64'hDEAD);
        chk("wr_keeps_rd_data", rd_data, 64'h4444_3333_2222_1111);

        preload(18'h00012, 16'h3333);
        preload(18'h00013, 16'h4444);
        run_op(1'b1, 1'b1, 32'h24, 32'hDEAD_BEEF, 1'b1);
        chk("sim_first_done", 64'(done_cyc), 64'd5);
        chk("sim_first_no_ready", 64'(ready_cnt), 64'd0);
        chk("sim_first_we_low", 64'(wel_cnt), 64'd2);
        run_op(1'b1, 1'b0, 32'h24, 32'd0, 1'b0);
        chk("sim_rd_pause_cycles", 64'(pause_cnt), 64'd9);
        chk("sim_rd_ready_cycle", 64'(ready_cyc), 64'd9);
        chk("sim_rd_line", rd_data, 64'hDEAD_BEEF_2222_1111);

        @(negedge clk);
        rd_en = 1'b1; address = 32'h20;
        repeat (4) @(negedge clk);
        rst = 1'b1; rd_en = 1'b0;
        #1;
        chk("rst_mid_pause_forced", {63'd0, pause}, 64'd0);
        @(negedge clk);
        #1;
        chk("rst_mid_rd_data", rd_data, 64'd0);
        chk("rst_mid_ctl_n", {61'd0, sram_ce_n, sram_oe_n, sram_we_n}, 64'd7);
        chk("rst_mid_ready", {63'd0, ready}, 64'd0);
        rst = 1'b0;
        ready_cnt = 0; pause_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (ready) ready_cnt++;
            if (pause) pause_cnt++;
        end
        chk("rst_mid_no_ready", 64'(ready_cnt), 64'd0);
        chk("rst_mid_idle", 64'(pause_cnt), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
